// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Misaligned-redirect trapping is enabled by defining IFU_MISALIGN_TRAP_EN.
package ifu_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   localparam int OPC_LSB  = 0;
   localparam int OPC_MSB  = 6;
   localparam int F3_LSB   = 12;
   localparam int F3_MSB   = 14;
   localparam int F7B5_BIT = 30;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ERR   = 2'd2
   } ifu_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer with flush; power-of-2 depth.
module ifu_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (reset_i || flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction fetch front end with redirect flush.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic        funct7b5,
   output logic        fetch_misaligned
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = 2 * XLEN;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   ifu_state_e     state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]  outst_q, outst_d;
   logic [CW-1:0]  drop_q, drop_d;
   logic           misal_q, misal_d;

   logic [CW-1:0]  fifo_cnt;
   logic           fifo_full, fifo_empty;
   logic [FW-1:0]  fifo_rdata;
   logic           push, pop, accept, mis_tgt;
   logic [CW:0]    credit;
   logic [31:0]    resp_pc;

`ifdef IFU_MISALIGN_TRAP_EN
   assign mis_tgt          = |pc_target[1:0];
   assign fetch_misaligned = misal_q;
`else
   assign mis_tgt          = 1'b0;
   assign fetch_misaligned = 1'b0;
`endif

   assign credit    = {1'b0, fifo_cnt} + {1'b0, outst_q};
   assign imem_req  = !reset && (state_q == ST_RUN) && !pc_src
                      && (credit < DEPTH_C);
   assign imem_addr = fetch_pc_q;
   assign accept    = imem_req && imem_ready;

   // Responses return in order, so the oldest outstanding one belongs
   // to the address issued outst_q requests ago.
   assign resp_pc = fetch_pc_q - 32'({outst_q, 2'b00});
   assign push    = imem_rvalid && (state_q == ST_RUN) && !pc_src;
   assign pop     = instr_valid && instr_ready;

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .reset_i (reset),
      .flush_i (pc_src),
      .push_i  (push),
      .wdata_i ({imem_rdata, resp_pc}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign instr_valid    = !reset && !fifo_empty;
   assign instr          = fifo_rdata[FW-1:XLEN];
   assign instr_pc       = fifo_rdata[XLEN-1:0];
   assign instr_pc_plus4 = instr_pc + 32'd4;
   assign opcode   = instr_valid ? instr[OPC_MSB:OPC_LSB] : '0;
   assign funct3   = instr_valid ? instr[F3_MSB:F3_LSB]   : '0;
   assign funct7b5 = instr_valid ? instr[F7B5_BIT]        : 1'b0;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      misal_d    = misal_q;
      outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid);
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (pc_src) fetch_pc_d = pc_target & ~32'h3;
      case (state_q)
         ST_FLUSH: begin
            if (pc_src) misal_d = mis_tgt;
            if (imem_rvalid) begin
               drop_d = drop_q - CW'(1);
               if (drop_q == CW'(1))
                  state_d = misal_d ? ST_ERR : ST_RUN;
            end
         end
         ST_RUN, ST_ERR: begin
            if (pc_src) begin
               misal_d = mis_tgt;
               drop_d  = outst_q - CW'(imem_rvalid);
               if (drop_d != '0)  state_d = ST_FLUSH;
               else if (mis_tgt)  state_d = ST_ERR;
               else               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         misal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         misal_q    <= misal_d;
      end
   end

   logic unused_full;
   assign unused_full = fifo_full;
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer entries (power of 2, >=2).
REQ-003 SHALL have ports clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have ports reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports pc_src  in  1  redirect request; pc_target  in  32  redirect address.
REQ-006 SHALL have ports imem_req  out  1 and imem_addr  out  32; imem_ready  in  1  request accepted when imem_req&&imem_ready.
REQ-007 SHALL have ports imem_rvalid  in  1 and imem_rdata  in  32; one in-order response per accepted request, at least 1 cycle after acceptance.
REQ-008 SHALL have ports instr_valid  out  1, instr_ready  in  1, instr  out  32, instr_pc  out  32, instr_pc_plus4  out  32.
REQ-009 SHALL have ports opcode  out  7 (instr[6:0]), funct3  out  3 (instr[14:12]), funct7b5  out  1 (instr[30]).
REQ-010 SHALL have port fetch_misaligned  out  1  sticky misaligned-redirect flag.

Function
REQ-011 SHALL hold fetch_pc; imem_addr = fetch_pc; fetch_pc += 4 on each accepted request (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-012 SHALL keep credit count = FIFO occupancy + outstanding requests; imem_req asserted only when credit < FIFO_DEPTH, state RUN, and pc_src=0.
REQ-013 SHALL write {imem_rdata, pc} into the FIFO on imem_rvalid in RUN when not discarding; FIFO never overflows by REQ-012.
REQ-014 SHALL drive instr_valid = FIFO non-empty; dequeue on instr_valid&&instr_ready; instr/instr_pc from head, instr_pc_plus4 = instr_pc+4.
REQ-015 SHALL allow enqueue and dequeue in the same cycle, occupancy unchanged.
REQ-016 SHALL implement states RUN, FLUSH, ERR.
REQ-017 On pc_src=1 (any state): dequeue that cycle still honoured; FIFO emptied; fetch_pc <= {pc_target[31:2],2'b00}; no request issued.
REQ-018 On redirect: drop_cnt <= outstanding minus 1 if imem_rvalid same cycle (that response discarded); next state FLUSH if result >0, else RUN.
REQ-019 In FLUSH: each imem_rvalid discarded and decrements drop_cnt; go to RUN on the cycle drop_cnt reaches 0; no requests.
REQ-020 Redirect while in FLUSH SHALL update fetch_pc only; drop_cnt decrements normally.
REQ-021 Outputs opcode/funct3/funct7b5 SHALL be combinational slices of instr; 0 when instr_valid=0.

Reset
REQ-022 While reset=1: state RUN, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, fetch_misaligned=0, imem_req=0, instr_valid=0.
REQ-023 Reset mid-flight SHALL abandon outstanding responses; memory is also reset, so responses arriving while reset=1 are ignored.
REQ-024 First request SHALL be issued in the first cycle with reset=0, imem_addr=RESET_PC.

Configuration
REQ-025 Macro IFU_MISALIGN_TRAP_EN defined: redirect with pc_target[1:0]!=0 enters ERR (after FLUSH drains), sets fetch_misaligned=1, issues no requests until an aligned redirect (clears flag, normal REQ-017/018) or reset.
REQ-026 Macro undefined: pc_target[1:0] ignored, ERR unreachable, fetch_misaligned tied 0.

Structure
REQ-027 Package ifu_pkg SHALL hold the state enum, RESET_PC default, XLEN=32, and instruction field bit positions.
REQ-028 FIFO SHALL be sub-module ifu_fifo (sync, parameterised depth/width, flush input, full/empty/count outputs).

Verification
REQ-029 Reset then imem_ready=1, 1-cycle rvalid, instr_ready=1 -> addresses 0,4,8,...; instr_pc matches; instr_pc_plus4=instr_pc+4.
REQ-030 instr_ready=0 for 10 cycles -> at most 2 requests accepted, instr_valid=1, head pc=0 held; no overflow.
REQ-031 pc_src=1, pc_target=32'h100 with 2 outstanding -> 2 responses discarded, FLUSH 2 cycles, next imem_addr=32'h100.
REQ-032 Redirect coincident with imem_rvalid and dequeue -> response dropped, branch consumed, FIFO empty next cycle.
REQ-033 fetch_pc=32'hFFFF_FFFC -> next imem_addr=32'h0.
REQ-034 With IFU_MISALIGN_TRAP_EN, pc_target=32'h102 -> fetch_misaligned=1, imem_req=0; then pc_target=32'h200 -> flag clears, fetch resumes at 32'h200; without macro same stimulus fetches 32'h100.
